trees_stream_ctrl: RTL

- Front-end controller for the tree-ensemble ping-pong core.
- Takes commands and one 64-bit valid/ready input stream from the accelerator DMA. Converts the stream into the core's tree-load and feature-load write ports, then pulses the core's start.
- Waits for the core's done, then drains the packed prediction memory onto a 64-bit valid/ready output stream.
- Sits between the DMA/config wrapper (upstream) and the ping-pong core (downstream).

---
 rtl/trees_stream_ctrl_pkg.sv | 29 ++
 rtl/trees_stream_ctrl_if.sv | 38 +++
 rtl/trees_stream_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/trees_stream_ctrl_pkg.sv
// Shared types and helpers for the tree-ensemble stream front-end.
// The controller walks a one-hot-free encoded state machine. It converts
// stream words into core write strobes and drains the prediction memory.
package trees_stream_ctrl_pkg;

    localparam int DEF_N_TREES          = 16;
    localparam int DEF_N_NODE_AND_LEAFS = 256;
    localparam int DEF_N_FEATURE        = 32;
    localparam int DEF_MAX_BURST        = 5000;

    // Derived quantities for the default core configuration.
    localparam int HALF_N_FEATURE = DEF_N_FEATURE / 2;
    localparam int TREE_WORDS     = DEF_N_TREES * DEF_N_NODE_AND_LEAFS;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_TREES = 3'd1,
        S_FEAT  = 3'd2,
        S_START = 3'd3,
        S_WAIT  = 3'd4,
        S_DRAIN = 3'd5
    } state_e;

    // Number of 64-bit prediction words that hold n byte-wide predictions.
    function automatic int unsigned ceil_div8(input int unsigned n);
        return (n + 32'd7) >> 3;
    endfunction

endpackage

// File: rtl/trees_stream_ctrl_if.sv
// Upstream handshake bundle: command channel, input stream, output stream.
// The master side is the DMA/config wrapper; the slave side is the controller.
interface trees_stream_ctrl_if
    import trees_stream_ctrl_pkg::*;
#(
    parameter int BL_W = $clog2(DEF_MAX_BURST) + 1
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_trees;
    logic [BL_W-1:0] cmd_burst_len;

    logic            in_valid;
    logic            in_ready;
    logic [63:0]     in_data;

    logic            out_valid;
    logic            out_ready;
    logic [63:0]     out_data;

    modport master (
        output cmd_valid, cmd_trees, cmd_burst_len,
        input  cmd_ready,
        output in_valid, in_data,
        input  in_ready,
        input  out_valid, out_data,
        output out_ready
    );

    modport slave (
        input  cmd_valid, cmd_trees, cmd_burst_len,
        output cmd_ready,
        input  in_valid, in_data,
        output in_ready,
        output out_valid, out_data,
        input  out_ready
    );
endinterface

// File: rtl/trees_stream_ctrl.sv
// Front-end controller for the tree-ensemble ping-pong core.
// It turns the DMA input stream into tree-load or feature-load writes and
// pulses start. After done it streams the packed predictions back out.
module trees_stream_ctrl
    import trees_stream_ctrl_pkg::*;
#(
    parameter int N_TREES          = DEF_N_TREES,
    parameter int N_NODE_AND_LEAFS = DEF_N_NODE_AND_LEAFS,
    parameter int N_FEATURE        = DEF_N_FEATURE,
    parameter int MAX_BURST        = DEF_MAX_BURST,
    localparam int BL_W   = $clog2(MAX_BURST) + 1,
    localparam int NODE_W = $clog2(N_NODE_AND_LEAFS),
    localparam int TREE_W = $clog2(N_TREES),
    localparam int FA_W   = $clog2(MAX_BURST * N_FEATURE / 2)
)
(
    input  logic              clk,
    input  logic              rst_n,
    trees_stream_ctrl_if.slave bus,
    output logic              load_trees,
    output logic [NODE_W-1:0] n_node,
    output logic [TREE_W-1:0] n_tree,
    output logic [63:0]       tree_nodes,
    output logic              load_features,
    output logic [FA_W-1:0]   feature_addr,
    output logic [63:0]       features2,
    output logic [BL_W-1:0]   burst_len,
    output logic              start,
    input  logic [63:0]       prediction,
    output logic [BL_W-1:0]   prediction_addr,
    input  logic              done,
    output logic              busy,
    output logic              cmd_done
);

    localparam int HALF_NF = N_FEATURE / 2;
    // One extra bit so the full feature-word total of a maximal burst fits.
    localparam int FC_W    = FA_W + 1;

    localparam logic [NODE_W-1:0] NODE_LAST = NODE_W'(N_NODE_AND_LEAFS - 1);
    localparam logic [TREE_W-1:0] TREE_LAST = TREE_W'(N_TREES - 1);

    state_e            state_q;
    logic [NODE_W-1:0] node_cnt_q;
    logic [TREE_W-1:0] tree_cnt_q;
    logic [FC_W-1:0]   feat_cnt_q;
    logic [FC_W-1:0]   feat_total_q;
    logic [BL_W-1:0]   burst_len_q;
    logic [BL_W-1:0]   prediction_addr_q;
    logic              load_trees_q;
    logic [NODE_W-1:0] n_node_q;
    logic [TREE_W-1:0] n_tree_q;
    logic [63:0]       tree_nodes_q;
    logic              load_features_q;
    logic [FA_W-1:0]   feature_addr_q;
    logic [63:0]       features2_q;
    logic              start_q;
    logic              out_valid_q;
    logic [63:0]       out_data_q;
    logic              cmd_done_q;

    logic [BL_W-1:0]   clamp_len_s;
    logic [FC_W-1:0]   feat_total_s;
    logic [BL_W-1:0]   out_last_s;

    // Clamp the requested burst length and derive the feature-word total.
    always_comb begin
        clamp_len_s = bus.cmd_burst_len;
        if (bus.cmd_burst_len > BL_W'(MAX_BURST)) begin
            clamp_len_s = BL_W'(MAX_BURST);
        end else begin
            clamp_len_s = bus.cmd_burst_len;
        end
        feat_total_s = FC_W'(int'(clamp_len_s) * HALF_NF);
        out_last_s   = BL_W'(ceil_div8(32'(burst_len_q)) - 32'd1);
    end

    // Main FSM: state, counters and every registered output toward core and DMA.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= S_IDLE;
            node_cnt_q        <= '0;
            tree_cnt_q        <= '0;
            feat_cnt_q        <= '0;
            feat_total_q      <= '0;
            burst_len_q       <= '0;
            prediction_addr_q <= '0;
            load_trees_q      <= 1'b0;
            n_node_q          <= '0;
            n_tree_q          <= '0;
            tree_nodes_q      <= 64'd0;
            load_features_q   <= 1'b0;
            feature_addr_q    <= '0;
            features2_q       <= 64'd0;
            start_q           <= 1'b0;
            out_valid_q       <= 1'b0;
            out_data_q        <= 64'd0;
            cmd_done_q        <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            load_trees_q    <= 1'b0;
            load_features_q <= 1'b0;
            start_q         <= 1'b0;
            cmd_done_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        node_cnt_q        <= '0;
                        tree_cnt_q        <= '0;
                        feat_cnt_q        <= '0;
                        prediction_addr_q <= '0;
                        if (bus.cmd_trees) begin
                            state_q <= S_TREES;
                        end else begin
                            burst_len_q  <= clamp_len_s;
                            feat_total_q <= feat_total_s;
                            // An empty burst has nothing to load or run.
                            if (clamp_len_s == '0) begin
                                cmd_done_q <= 1'b1;
                                state_q    <= S_IDLE;
                            end else begin
                                state_q <= S_FEAT;
                            end
                        end
                    end
                end
                S_TREES: begin
                    if (bus.in_valid) begin
                        load_trees_q <= 1'b1;
                        tree_nodes_q <= bus.in_data;
                        n_node_q     <= node_cnt_q;
                        n_tree_q     <= tree_cnt_q;
                        if (node_cnt_q == NODE_LAST) begin
                            node_cnt_q <= '0;
                            if (tree_cnt_q == TREE_LAST) begin
                                tree_cnt_q <= '0;
                                cmd_done_q <= 1'b1;
                                state_q    <= S_IDLE;
                            end else begin
                                tree_cnt_q <= tree_cnt_q + TREE_W'(1);
                            end
                        end else begin
                            node_cnt_q <= node_cnt_q + NODE_W'(1);
                        end
                    end
                end
                S_FEAT: begin
                    if (bus.in_valid) begin
                        load_features_q <= 1'b1;
                        features2_q     <= bus.in_data;
                        feature_addr_q  <= feat_cnt_q[FA_W-1:0];
                        feat_cnt_q      <= feat_cnt_q + FC_W'(1);
                        if (feat_cnt_q == (feat_total_q - FC_W'(1))) begin
                            state_q <= S_START;
                        end
                    end
                end
                S_START: begin
                    // The final feature write landed on the previous cycle.
                    start_q <= 1'b1;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (done) begin
                        prediction_addr_q <= '0;
                        out_valid_q       <= 1'b0;
                        state_q           <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!out_valid_q) begin
                        // Capture the combinational read of the current address.
                        out_valid_q <= 1'b1;
                        out_data_q  <= prediction;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (prediction_addr_q == out_last_s) begin
                            cmd_done_q <= 1'b1;
                            state_q    <= S_IDLE;
                        end else begin
                            prediction_addr_q <= prediction_addr_q + BL_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.in_ready  = (state_q == S_TREES) || (state_q == S_FEAT);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign busy          = (state_q != S_IDLE);

    assign load_trees      = load_trees_q;
    assign n_node          = n_node_q;
    assign n_tree          = n_tree_q;
    assign tree_nodes      = tree_nodes_q;
    assign load_features   = load_features_q;
    assign feature_addr    = feature_addr_q;
    assign features2       = features2_q;
    assign burst_len       = burst_len_q;
    assign start           = start_q;
    assign prediction_addr = prediction_addr_q;
    assign cmd_done        = cmd_done_q;

endmodule
